// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder decoder: 2-flop synchronizer, deglitch filter, Gray decode and signed position.
// Define ENC_PERIOD_EN to add measurement of the clk cycles between counted events.
module quad_encoder_decoder #(
  parameter int POS_WIDTH = 32,
  parameter int PER_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [3:0]                  deglitch_div,
  input  logic [1:0]                  enc,
  input  logic                        pos_set,
  input  logic [POS_WIDTH-1:0]        pos_set_val,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        inc,
  output logic                        dec,
  output logic                        err,
  output logic [PER_WIDTH-1:0]        period,
  output logic                        period_valid
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [POS_WIDTH-1:0] POS_ONE = 1;

  state_t               state;
  logic [1:0]           sync1, sync2, cand, filt, bin_prev, bin_new, step;
  logic [3:0]           cnt;
  logic                 cnt_done, filt_upd;
  logic [POS_WIDTH-1:0] pos_q;

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_comb begin
    cnt_done = (cnt == deglitch_div);
    bin_new  = gray2bin(filt);
    step     = bin_new - bin_prev;
  end

  // filt_upd marks a fresh filt value; the event it implies is decoded and
  // registered one edge later, with en sampled on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      cand     <= 2'b00;
      cnt      <= 4'd0;
      filt     <= 2'b00;
      bin_prev <= 2'b00;
      filt_upd <= 1'b0;
      state    <= INIT;
      inc      <= 1'b0;
      dec      <= 1'b0;
      err      <= 1'b0;
      pos_q    <= '0;
    end else begin
      sync1    <= enc;
      sync2    <= sync1;
      filt_upd <= 1'b0;

      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= 4'd0;
      end else if (state == INIT && cnt_done) begin
        filt     <= cand;
        bin_prev <= gray2bin(cand);
        state    <= RUN;
      end else if (state == RUN && cand != filt && cnt_done) begin
        filt     <= cand;
        filt_upd <= 1'b1;
      end else begin
        cnt <= (cnt < deglitch_div) ? cnt + 4'd1 : deglitch_div;
      end

      inc <= 1'b0;
      dec <= 1'b0;
      err <= 1'b0;
      if (filt_upd) begin
        bin_prev <= bin_new;
        if (en) begin
          inc <= (step == 2'd1);
          dec <= (step == 2'd3);
          err <= (step == 2'd2);
        end
      end

      // A load wins over a simultaneous count; the pulse above is still emitted.
      if (pos_set)
        pos_q <= pos_set_val;
      else if (filt_upd && en && step == 2'd1)
        pos_q <= pos_q + POS_ONE;
      else if (filt_upd && en && step == 2'd3)
        pos_q <= pos_q - POS_ONE;
    end
  end

  assign position = pos_q;

`ifdef ENC_PERIOD_EN
  localparam logic [PER_WIDTH-1:0] PER_ONE = 1;

  logic [PER_WIDTH-1:0] per_cnt;
  logic                 count_ev;

  assign count_ev = filt_upd && en && (step == 2'd1 || step == 2'd3);

  // Free-running cycle counter, restarted at 1 on every counted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= count_ev;
      if (count_ev) begin
        period  <= per_cnt;
        per_cnt <= PER_ONE;
      end else if (state == RUN && per_cnt != '1) begin
        per_cnt <= per_cnt + PER_ONE;
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Randomized and directed bench for quad_encoder_decoder against a sample-history model.
// The model says filt takes value v once the raw input has been sampled as v on d+2 consecutive edges.
module tb_quad_encoder_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  deglitch_div = 4'd0;
  logic [1:0]  enc = 2'b00;
  logic        pos_set = 1'b0;
  logic [31:0] pos_set_val = 32'd0;
  logic signed [31:0] position;
  logic        inc, dec, err;
  logic [15:0] period;
  logic        period_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quad_encoder_decoder #(.POS_WIDTH(32), .PER_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .deglitch_div(deglitch_div), .enc(enc),
    .pos_set(pos_set), .pos_set_val(pos_set_val), .position(position),
    .inc(inc), .dec(dec), .err(err), .period(period), .period_valid(period_valid)
  );

  int          edge_no = 10;
  bit          model_ok = 1'b0;
  int          hist [64];
  bit          m_run, pend, m_inc, m_dec, m_err, m_pv;
  int          m_filt, pend_step, per_ref;
  logic [31:0] m_pos;
  logic [15:0] m_period;

  // Position of a Gray code within the forward cycle 00,01,11,10.
  function automatic int phase(input int g);
    case (g)
      0: return 0;
      1: return 1;
      3: return 2;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int v, diff;
    bit ok;
    edge_no++;
    if (rst) begin
      model_ok = 1'b1;
      hist[(edge_no - 3) % 64] = 4;
      hist[(edge_no - 2) % 64] = 0;
      hist[(edge_no - 1) % 64] = 0;
      hist[edge_no % 64]       = 0;
      m_run = 0; m_filt = 0; pend = 0; m_pos = 0;
      m_inc = 0; m_dec = 0; m_err = 0; m_pv = 0; m_period = 0; per_ref = 0;
    end else begin
      m_inc = 0; m_dec = 0; m_err = 0; m_pv = 0;
      if (pend && en) begin
        m_inc = (pend_step == 1);
        m_dec = (pend_step == 3);
        m_err = (pend_step == 2);
      end
      pend = 0;
      if (pos_set) m_pos = pos_set_val;
      else if (m_inc) m_pos = m_pos + 32'd1;
      else if (m_dec) m_pos = m_pos - 32'd1;
      if (m_inc || m_dec) begin
        diff = edge_no - per_ref;
        m_period = (diff > 65535) ? 16'hFFFF : diff[15:0];
        m_pv = 1;
        per_ref = edge_no;
      end
      hist[edge_no % 64] = int'(enc);
      v  = hist[(edge_no - 2) % 64];
      ok = (v != 4);
      for (int j = 3; j <= int'(deglitch_div) + 3; j++)
        if (hist[(edge_no - j) % 64] != v) ok = 0;
      if (ok && !m_run) begin
        m_filt = v; m_run = 1; per_ref = edge_no + 1;
      end else if (ok && v != m_filt) begin
        pend = 1;
        pend_step = (phase(v) - phase(m_filt) + 4) % 4;
        m_filt = v;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_no);
    end
  endtask

  int n_inc = 0, n_dec = 0, n_err = 0, last_inc_edge = 0;

  always @(negedge clk) begin
    if (model_ok) begin
      check_output("inc", {31'd0, inc}, {31'd0, m_inc});
      check_output("dec", {31'd0, dec}, {31'd0, m_dec});
      check_output("err", {31'd0, err}, {31'd0, m_err});
      check_output("position", position, m_pos);
`ifdef ENC_PERIOD_EN
      check_output("period", {16'd0, period}, {16'd0, m_period});
      check_output("period_valid", {31'd0, period_valid}, {31'd0, m_pv});
`else
      check_output("period", {16'd0, period}, 32'd0);
      check_output("period_valid", {31'd0, period_valid}, 32'd0);
`endif
      n_inc += int'(inc);
      n_dec += int'(dec);
      n_err += int'(err);
      if (inc) last_inc_edge = edge_no;
    end
  end

  int drive_edge = 0;

  task automatic apply_stimulus(input logic [1:0] v, input int cycles);
    enc = v;
    drive_edge = edge_no + 1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] d, input logic [1:0] v);
    rst = 1'b1;
    deglitch_div = d;
    enc = v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] fwd [4];
    logic [1:0] rev [4];
    int b_inc, b_dec, b_err;
    fwd = '{2'b01, 2'b11, 2'b10, 2'b00};
    rev = '{2'b10, 2'b11, 2'b01, 2'b00};

    @(negedge clk);
    do_reset(4'd0, 2'b00);
    check_output("reset_position", position, 32'd0);
    check_output("reset_period", {16'd0, period}, 32'd0);
    apply_stimulus(2'b00, 10);
    b_inc = n_inc;
    apply_stimulus(2'b01, 10);
    check_output("d0_inc_count", n_inc - b_inc, 32'd1);
    check_output("d0_latency", last_inc_edge - drive_edge, 32'd4);
    check_output("d0_position", position, 32'd1);

    do_reset(4'd7, 2'b00);
    apply_stimulus(2'b00, 20);
    b_inc = n_inc + n_dec + n_err;
    apply_stimulus(2'b01, 3);
    apply_stimulus(2'b00, 30);
    check_output("glitch_events", n_inc + n_dec + n_err - b_inc, 32'd0);
    check_output("glitch_position", position, 32'd0);

    do_reset(4'd2, 2'b00);
    apply_stimulus(2'b00, 20);
    b_inc = n_inc; b_dec = n_dec;
    for (int i = 0; i < 8; i++) apply_stimulus(fwd[i % 4], 20);
    for (int i = 0; i < 8; i++) apply_stimulus(rev[i % 4], 20);
    check_output("walk_inc_count", n_inc - b_inc, 32'd8);
    check_output("walk_dec_count", n_dec - b_dec, 32'd8);
    check_output("walk_position", position, 32'd0);
`ifdef ENC_PERIOD_EN
    check_output("walk_period", {16'd0, period}, 32'd20);
`endif

    do_reset(4'd1, 2'b00);
    apply_stimulus(2'b00, 10);
    b_inc = n_inc; b_dec = n_dec; b_err = n_err;
    apply_stimulus(2'b11, 15);
    check_output("jump_err_count", n_err - b_err, 32'd1);
    check_output("jump_count_events", (n_inc - b_inc) + (n_dec - b_dec), 32'd0);
    check_output("jump_position", position, 32'd0);

    do_reset(4'd0, 2'b00);
    apply_stimulus(2'b00, 10);
    pos_set = 1'b1; pos_set_val = 32'h7FFF_FFFF;
    @(negedge clk);
    pos_set = 1'b0;
    apply_stimulus(2'b01, 10);
    check_output("wrap_position", position, 32'h8000_0000);
    b_inc = n_inc;
    apply_stimulus(2'b11, 4);
    pos_set = 1'b1; pos_set_val = 32'hFFFF_FFCE;
    @(negedge clk);
    pos_set = 1'b0;
    repeat (6) @(negedge clk);
    check_output("load_position", position, 32'hFFFF_FFCE);
    check_output("load_inc_count", n_inc - b_inc, 32'd1);
    check_output("load_inc_edge", last_inc_edge - drive_edge, 32'd4);

    do_reset(4'd0, 2'b00);
    apply_stimulus(2'b00, 10);
    apply_stimulus(2'b01, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_no_pulse", {31'd0, inc}, 32'd0);
    apply_stimulus(2'b01, 10);

    do_reset(4'd2, 2'b10);
    b_inc = n_inc + n_dec + n_err;
    apply_stimulus(2'b10, 20);
    check_output("init_absorb_events", n_inc + n_dec + n_err - b_inc, 32'd0);
    en = 1'b0;
    apply_stimulus(2'b00, 20);
    apply_stimulus(2'b01, 20);
    en = 1'b1;
    apply_stimulus(2'b01, 20);
    check_output("disabled_events", n_inc + n_dec + n_err - b_inc, 32'd0);
    check_output("disabled_position", position, 32'd0);
    apply_stimulus(2'b11, 20);
    check_output("reenabled_position", position, 32'd1);

    do_reset(4'($urandom_range(0, 3)), 2'b00);
    for (int i = 0; i < 200; i++) begin
      enc = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 12)) begin
        pos_set = ($urandom_range(0, 31) == 0);
        pos_set_val = $urandom;
        rst = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      pos_set = 1'b0;
      rst = 1'b0;
    end
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_decoder.md
QUAD_ENCODER_DECODER -- requirements
Module: quad_encoder_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 32: signed position counter width.
REQ-002 SHALL have parameter PER_WIDTH, default 16: period counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic acts on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: counting enable.
REQ-006 SHALL have port deglitch_div, input, 4: filter threshold d.
REQ-007 SHALL have port enc, input, 2: raw asynchronous quadrature input, Gray-coded.
REQ-008 SHALL have port pos_set, input, 1: load position strobe.
REQ-009 SHALL have port pos_set_val, input, POS_WIDTH: value loaded by pos_set.
REQ-010 SHALL have port position, output, POS_WIDTH: signed encoder position.
REQ-011 SHALL have ports inc, dec and err, each output, 1: one-cycle event pulses.
REQ-012 SHALL have port period, output, PER_WIDTH: clk cycles between the last two counted events.
REQ-013 SHALL have port period_valid, output, 1: one-cycle pulse when period updates.

Function
REQ-014 SHALL pass enc through a 2-flop synchronizer before any other use.
REQ-015 SHALL run a deglitch filter on the synchronized input:
- Candidate register cand; stability counter cnt.
- If the synced value differs from cand, cand loads it and cnt clears to 0.
- Else, if cand differs from filt and cnt equals d, filt loads cand.
- Else cnt increments, saturating at d.
REQ-016 SHALL decode bin = {filt[1], filt[1]^filt[0]} and compare it with the previous bin on each filt update:
- Difference +1 mod 4: inc.
- Difference -1 mod 4: dec.
- Difference 2: err, with no position change.
REQ-017 SHALL register inc, dec and err one cycle after the filt update; position SHALL change on the same edge as the pulse.
REQ-018 SHALL have total latency d+5 edges: a raw change first sampled on edge 1 gives inc/dec/err high after edge d+5.
REQ-019 SHALL implement a 2-state FSM:
- INIT, entered on reset: the first stable value (cnt==d) loads filt and bin-previous with no event, then goes to RUN.
- RUN: normal decoding.
REQ-020 SHALL keep updating filt and bin-previous while en=0, but suppress inc/dec/err and position changes, so re-enabling produces no spurious count.
REQ-021 SHALL, on pos_set, load position from pos_set_val on the next edge; a simultaneous count is dropped, but its inc/dec pulse is still emitted.
REQ-022 SHALL wrap position modulo 2^POS_WIDTH (two's complement) with no saturation.
REQ-023 SHALL, when 4 or more consecutive synced changes occur faster than d+1 cycles, produce no filt change and no events.

Reset
REQ-024 SHALL clear synchronizer, cand, cnt, filt, position, period and all pulses to 0, and set the FSM to INIT.
REQ-025 SHALL treat rst asserted mid-transition as an abort: no pulse in the cycle after rst.

Configuration
REQ-026 SHALL, with macro ENC_PERIOD_EN defined, implement period measurement as follows:
- A counter runs at 1 per clk from the first RUN cycle, saturating at all-ones.
- On each inc/dec: period loads the counter value, period_valid pulses on the same edge, and the counter reloads to 1.
- err does not affect the counter.
REQ-027 SHALL, without ENC_PERIOD_EN, tie period to 0 and period_valid to 0, with no counter logic.

Verification
REQ-028 SHALL cover: d=0, enc 00 held 10 cycles, then 01 -> one inc pulse 5 edges after the change, position=1.
REQ-029 SHALL cover: d=7, enc glitch 00->01->00 lasting 3 cycles -> no pulse, position unchanged.
REQ-030 SHALL cover: d=2, 8 forward steps then 8 reverse steps, each held 20 cycles -> 8 inc then 8 dec, position returns to 0; with ENC_PERIOD_EN, period=20 from the second event on.
REQ-031 SHALL cover: d=1, filt jumps 00->11 (bin 0->2) -> single err pulse, position unchanged.
REQ-032 SHALL cover: position=0x7FFFFFFF with one inc -> 0x80000000; pos_set=1 with val=-50 coinciding with an inc -> position=-50 and inc pulse still seen.
REQ-033 SHALL cover: rst held with enc=10, then released -> INIT absorbs 10 with no pulse; en=0 during two steps, then en=1 -> position unchanged.
